uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

UART transmitter with a small input FIFO for the ECG filter board. It serialises filtered sample bytes onto the host-bound UART line as 8N1 frames, LSB first, using the same baud arithmetic as the receive path, so the two ends interoperate at 115200 baud from a 50 MHz clock. Upstream logic pushes bytes through a valid/ready handshake. Frames go out back-to-back with no idle gap while the FIFO holds data.

## Interface
- CLK_FREQ, 50000000: input clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s.
- BIT_PERIOD, CLK_FREQ / BAUD_RATE (434): clocks per bit, integer division, must be ≥ 2.
- FIFO_DEPTH, 4: byte entries, power of two, ≥ 2.
- Clk  input  1  system clock, all logic on rising edge.
- Rst  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send, sampled when tx_valid && tx_ready.
- tx_valid  input  1  upstream has a byte.
- tx_ready  output  1  FIFO not full, combinational from count.
- tx  output  1  UART line, idle high, registered.
- tx_busy  output  1  high while a frame (start..stop) is on the line.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte in flight.

## Operation
- Reset, sampled on the Clk edge with Rst=1, sets:
  - tx=1, tx_busy=0, fifo_count=0, tx_ready=1.
  - FSM to IDLE, baud counter and bit index to 0.
  - FIFO pointers to 0. Contents are don't-care.
- Reset mid-frame aborts the frame. tx is 1 from the next edge and queued bytes are discarded.
- FIFO behaviour:
  - Push when tx_valid && tx_ready.
  - Pop when the FSM loads a byte.
  - Push and pop in the same cycle: fifo_count unchanged, both take effect.
  - tx_valid while full (tx_ready=0) is ignored and the byte is dropped by protocol. Upstream must hold it.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: tx=1, tx_busy=0. If fifo_count≠0: pop the head into the shift register and go to START.
  - START: tx=0 for BIT_PERIOD cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[bit index] for BIT_PERIOD cycles each, bits 0..7 (LSB first), then go to STOP.
  - STOP: tx=1 for BIT_PERIOD cycles. At the end, if fifo_count≠0, pop and go directly to START. Otherwise go to IDLE.
- Baud counter:
  - Counts 0..BIT_PERIOD-1 and wraps to 0 on each bit boundary.
  - Width is 16 bits. BIT_PERIOD must fit.
- The FSM never reads the FIFO outside IDLE or the last cycle of STOP. It never pops an empty FIFO.

## Timing
- Byte accepted at edge k with the FSM in IDLE and the FIFO empty:
  - fifo_count=1 after edge k.
  - Pop at edge k+1: tx=0 and tx_busy=1 from edge k+1, fifo_count back to 0.
- Frame length is exactly 10×BIT_PERIOD cycles:
  - start bit from edge k+1
  - data bit i from edge k+1+(i+1)×BIT_PERIOD
  - stop bit from edge k+1+9×BIT_PERIOD
- Back-to-back frames: the next start bit begins at the edge immediately after the last stop-bit cycle. tx_busy stays high and there is no idle cycle.
- Frame ending with an empty FIFO: IDLE at edge k+1+10×BIT_PERIOD, tx_busy=0 from that edge.
- tx_ready responds combinationally to fifo_count:
  - Full FIFO plus a pop frees one slot. tx_ready rises the cycle after the pop edge.
  - There is no same-cycle bypass of the full condition.
- tx is a flop output with no glitches.

## Test plan
All scenarios use the overrides CLK_FREQ=1000, BAUD_RATE=100 (BIT_PERIOD=10) unless noted.
- Reset idle: assert Rst for 3 cycles, release → tx=1, tx_busy=0, tx_ready=1, fifo_count=0, tx stays 1 for 100 cycles.
- Single byte 0x55: push at edge k.
  - tx low from k+1 for 10 cycles, then bits 1,0,1,0,1,0,1,0 at 10 cycles each, then stop high.
  - tx_busy falls at k+101.
- Back-to-back and full:
  - Push 0xA3, 0x0F, 0xFF, 0x00, 0x81 on consecutive cycles → first byte pops immediately; the remaining four fill the FIFO (fifo_count=4); tx_ready=0.
  - Five contiguous frames of 100 cycles each, bytes in order.
  - tx_ready returns high the cycle after the second byte's pop.
- Simultaneous push and pop: push 0x3C on the exact cycle STOP ends with one byte queued → fifo_count stays 1 and both bytes are transmitted in order.
- Reset mid-frame: Rst asserted at bit 4 of 0xC6 with 2 bytes queued → tx=1 at the next edge, fifo_count=0, no further frames.
- Loopback at defaults (434 clocks/bit): tx wired to the receive path's rx, send 0x00..0xFF → every rx_data matches the sent byte, one rx_ready pulse per byte.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small byte FIFO; frames leave back-to-back while data is queued.
// Serialises LSB first at BIT_PERIOD clocks per bit; tx is always a flop output.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | line high, not busy; pops the FIFO head as soon as it exists
//   S_START | start bit (tx=0) for BIT_PERIOD cycles
//   S_DATA  | data bits 0..7, LSB first, BIT_PERIOD cycles each
//   S_STOP  | stop bit (tx=1); on its last cycle chains to the next byte
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int BIT_PERIOD = CLK_FREQ / BAUD_RATE,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [15:0]      BAUD_LAST = 16'(BIT_PERIOD - 1);
   localparam logic [CNT_W-1:0] FULL      = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t           state;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [15:0]      baud_cnt;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_nxt;
   logic [7:0]       shift;
   logic             push;
   logic             pop;
   logic             bit_end;

   assign tx_ready   = (count != FULL);
   assign push       = tx_valid && tx_ready;
   assign bit_end    = (baud_cnt == BAUD_LAST);
   assign bit_nxt    = bit_idx + 3'd1;
   assign fifo_count = count;

   // The FSM only takes a byte in IDLE or on the final stop-bit cycle, and never from an empty FIFO.
   assign pop = (count != '0) && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

   always_ff @(posedge Clk) begin
      if (push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               tx       <= 1'b1;
               tx_busy  <= 1'b0;
               baud_cnt <= '0;
               if (pop) begin
                  shift   <= mem[rd_ptr];
                  tx      <= 1'b0;
                  tx_busy <= 1'b1;
                  state   <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shift[0];
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= S_STOP;
                  end else begin
                     bit_idx <= bit_nxt;
                     tx      <= shift[bit_nxt];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     // Chain straight into the next start bit; tx_busy stays high.
                     shift <= mem[rd_ptr];
                     tx    <= 1'b0;
                     state <= S_START;
                  end else begin
                     tx_busy <= 1'b0;
                     state   <= S_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: cycle-exact frame checks at 10 clocks/bit, a line-decoding
// scoreboard for byte order, and a short loopback decode at the default 434 clocks/bit.
module tb_uart_tx_fifo;

   localparam int BP   = 10;
   localparam int BP_D = 434;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;
   logic [2:0] fifo_count;

   logic [7:0] tx_data_d = 8'h00;
   logic       tx_valid_d = 1'b0;
   logic       tx_ready_d;
   logic       tx_d;
   logic       tx_busy_d;
   logic [2:0] fifo_count_d;

   uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
      .Clk(Clk), .Rst(Rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count));

   uart_tx_fifo dut_d (
      .Clk(Clk), .Rst(Rst), .tx_data(tx_data_d), .tx_valid(tx_valid_d), .tx_ready(tx_ready_d),
      .tx(tx_d), .tx_busy(tx_busy_d), .fifo_count(fifo_count_d));

   always #5 Clk = ~Clk;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] sb[$];
   bit         mon_en = 1'b0;
   int         rst_cnt = 0;

   always @(posedge Clk) if (Rst) rst_cnt <= rst_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Line decoder for the main DUT: detects the start bit, samples mid-bit, checks against the scoreboard.
   initial begin : monitor
      logic [7:0] d;
      logic       s0;
      logic       s9;
      int         r0;
      logic [7:0] e;
      forever begin
         @(negedge Clk);
         if (mon_en && !Rst && tx === 1'b0) begin
            r0 = rst_cnt;
            repeat (BP/2) @(negedge Clk);
            s0 = tx;
            for (int i = 0; i < 8; i++) begin
               repeat (BP) @(negedge Clk);
               d[i] = tx;
            end
            repeat (BP) @(negedge Clk);
            s9 = tx;
            if (rst_cnt == r0) begin
               if (sb.size() == 0) begin
                  check("frame_expected", sb.size(), 1);
               end else begin
                  e = sb.pop_front();
                  check("frame_data", d, e);
                  check("start_bit", s0, 0);
                  check("stop_bit", s9, 1);
               end
            end
         end
      end
   end

   task automatic decode_d(output logic [7:0] d, output logic s9, output bit got);
      int w;
      w = 0; got = 1'b0; d = 8'h00; s9 = 1'b0;
      while (tx_d !== 1'b0 && w < 10*BP_D*3) begin
         @(negedge Clk);
         w++;
      end
      if (tx_d === 1'b0) begin
         got = 1'b1;
         repeat (BP_D/2) @(negedge Clk);
         for (int i = 0; i < 8; i++) begin
            repeat (BP_D) @(negedge Clk);
            d[i] = tx_d;
         end
         repeat (BP_D) @(negedge Clk);
         s9 = tx_d;
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // line value per bit slot, slot 0 = start bit
   } vec_t;

   vec_t       vecs[3];
   logic [7:0] b3[5];
   logic [7:0] lb[4];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int         etx, ebusy, ecnt, erdy, hi;
      int         pushes, pops, f, exp_cnt;
      logic       exp_tx, exp_busy;
      logic [9:0] fr;
      logic [7:0] dd;
      logic       s9d;
      bit         gotd;

      vecs[0] = '{8'h55, 10'b1010101010};
      vecs[1] = '{8'h01, 10'b1000000010};
      vecs[2] = '{8'hF0, 10'b1111100000};
      b3[0] = 8'hA3; b3[1] = 8'h0F; b3[2] = 8'hFF; b3[3] = 8'h00; b3[4] = 8'h81;
      lb[0] = 8'h00; lb[1] = 8'hA5; lb[2] = 8'hFF; lb[3] = 8'h3C;

      // Reset and idle line
      Rst = 1'b1;
      repeat (3) @(negedge Clk);
      Rst = 1'b0;
      check("rst_tx", tx, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_ready", tx_ready, 1);
      check("rst_count", fifo_count, 0);
      hi = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge Clk);
         if (tx !== 1'b1 || tx_busy !== 1'b0) hi++;
      end
      check("idle_line_high", hi, 0);
      mon_en = 1'b1;

      // Single frames from the vector table
      for (int v = 0; v < 3; v++) begin
         etx = 0; ebusy = 0;
         tx_data = vecs[v].data; tx_valid = 1'b1; sb.push_back(vecs[v].data);
         @(negedge Clk);
         tx_valid = 1'b0;
         check("single_count_after_push", fifo_count, 1);
         check("single_tx_before_start", tx, 1);
         for (int c = 1; c <= 100; c++) begin
            @(negedge Clk);
            if (tx !== vecs[v].frame[(c-1)/10]) etx++;
            if (tx_busy !== 1'b1) ebusy++;
            if (c == 1) check("single_count_after_pop", fifo_count, 0);
         end
         check("single_frame_tx", etx, 0);
         check("single_busy_in_frame", ebusy, 0);
         @(negedge Clk);
         check("single_busy_fall", tx_busy, 0);
         check("single_tx_idle", tx, 1);
      end

      // Back-to-back frames, FIFO full, pushes while full are dropped
      etx = 0; ebusy = 0; ecnt = 0; erdy = 0;
      for (int c = 0; c <= 501; c++) begin
         if (c < 5) begin
            tx_valid = 1'b1; tx_data = b3[c]; sb.push_back(b3[c]);
         end else if (c < 10) begin
            tx_valid = 1'b1; tx_data = 8'h99;
         end else begin
            tx_valid = 1'b0;
         end
         @(negedge Clk);
         pushes = (c < 4) ? c + 1 : 5;
         pops = 0;
         for (int p = 0; p < 5; p++) if (c >= 1 + 100*p) pops++;
         exp_cnt = pushes - pops;
         if (c >= 1 && c <= 500) begin
            f = c - 1;
            fr = {1'b1, b3[f/100], 1'b0};
            exp_tx = fr[(f%100)/10];
            exp_busy = 1'b1;
         end else begin
            exp_tx = 1'b1;
            exp_busy = 1'b0;
         end
         if (tx !== exp_tx) etx++;
         if (tx_busy !== exp_busy) ebusy++;
         if (fifo_count !== 3'(exp_cnt)) ecnt++;
         if (tx_ready !== (exp_cnt != 4)) erdy++;
         if (c == 4) begin
            check("b2b_full_count", fifo_count, 4);
            check("b2b_full_ready", tx_ready, 0);
         end
         if (c == 100) check("b2b_ready_before_pop", tx_ready, 0);
         if (c == 101) begin
            check("b2b_ready_after_pop", tx_ready, 1);
            check("b2b_count_after_pop", fifo_count, 3);
         end
      end
      check("b2b_tx_seq", etx, 0);
      check("b2b_busy_seq", ebusy, 0);
      check("b2b_count_seq", ecnt, 0);
      check("b2b_ready_seq", erdy, 0);

      // Push landing on the same edge as the stop-bit pop
      ebusy = 0;
      for (int c = 0; c <= 301; c++) begin
         tx_valid = 1'b0;
         if (c == 0)   begin tx_valid = 1'b1; tx_data = 8'h11; sb.push_back(8'h11); end
         if (c == 1)   begin tx_valid = 1'b1; tx_data = 8'h22; sb.push_back(8'h22); end
         if (c == 101) begin tx_valid = 1'b1; tx_data = 8'h3C; sb.push_back(8'h3C); end
         @(negedge Clk);
         if (c == 1)   check("simul_count_first", fifo_count, 1);
         if (c == 100) check("simul_count_before", fifo_count, 1);
         if (c == 101) check("simul_count_same_edge", fifo_count, 1);
         if (c == 201) check("simul_count_drained", fifo_count, 0);
         if (c >= 1 && c <= 300 && tx_busy !== 1'b1) ebusy++;
      end
      tx_valid = 1'b0;
      check("simul_busy_contiguous", ebusy, 0);
      check("simul_busy_end", tx_busy, 0);
      check("scoreboard_drained", sb.size(), 0);

      // Reset during bit 4 of 0xC6 with two bytes queued
      etx = 0;
      for (int c = 0; c <= 155; c++) begin
         tx_valid = 1'b0;
         if (c == 0) begin tx_valid = 1'b1; tx_data = 8'hC6; sb.push_back(8'hC6); end
         if (c == 1) begin tx_valid = 1'b1; tx_data = 8'h12; sb.push_back(8'h12); end
         if (c == 2) begin tx_valid = 1'b1; tx_data = 8'h34; sb.push_back(8'h34); end
         Rst = (c == 55);
         @(negedge Clk);
         if (c == 2) check("rstmid_count_queued", fifo_count, 2);
         if (c == 54) begin
            check("rstmid_bit4_tx", tx, 0);
            check("rstmid_busy_before", tx_busy, 1);
         end
         if (c == 55) begin
            check("rstmid_tx", tx, 1);
            check("rstmid_count", fifo_count, 0);
            check("rstmid_busy", tx_busy, 0);
            check("rstmid_ready", tx_ready, 1);
         end
         if (c > 55 && (tx !== 1'b1 || tx_busy !== 1'b0)) etx++;
      end
      Rst = 1'b0;
      check("rstmid_no_frames", etx, 0);
      sb.delete();

      // Loopback decode at default rate
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               tx_valid_d = 1'b1; tx_data_d = lb[i];
               @(negedge Clk);
            end
            tx_valid_d = 1'b0;
         end
         begin
            for (int i = 0; i < 4; i++) begin
               decode_d(dd, s9d, gotd);
               check("lb_frame_found", gotd, 1);
               check("lb_data", dd, lb[i]);
               check("lb_stop", s9d, 1);
            end
         end
      join
      repeat (500) @(negedge Clk);
      check("lb_idle_tx", tx_d, 1);
      check("lb_idle_busy", tx_busy_d, 0);
      check("lb_idle_count", fifo_count_d, 0);
      check("lb_idle_ready", tx_ready_d, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
